// File: rtl/fir_filt_mc.sv
// rtl/fir_filt_mc.sv - multichannel FIR filter, one MAC per channel, shared coefficient set
// Optional FIR_SAT_EN: clamp results to the sample range instead of wrapping.
module fir_filt_mc #(
  parameter int sig_width  = 12,
  parameter int coef_width = 18,
  parameter int acc_width  = 40,
  parameter int tap_count  = 16,
  parameter int chan_count = 2,
  parameter int max_shift  = 32,
  localparam int tap_w     = $clog2(tap_count),
  localparam int shift_w   = $clog2(max_shift)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             coef_we,
  input  logic [tap_w-1:0]                 coef_addr,
  input  logic [coef_width-1:0]            coef_wdata,
  output logic                             coef_ack,
  output logic [coef_width-1:0]            coef_rdata,
  input  logic                             shift_we,
  input  logic [shift_w-1:0]               shift_i,
  output logic [shift_w-1:0]               shift_r,
  input  logic                             conv_done,
  input  logic [chan_count*sig_width-1:0]  adc_in,
  output logic [chan_count*sig_width-1:0]  filt_out,
  output logic                             filt_done,
  output logic                             busy,
  output logic                             overrun
);

  localparam int prod_w = sig_width + coef_width;
  localparam logic [tap_w-1:0] last_tap = tap_w'(tap_count - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic                        cc_prev;
  logic                        cc_rising;
  logic [tap_w-1:0]            wptr;
  logic [tap_w-1:0]            rptr;
  logic [tap_w-1:0]            tap_k;
  logic [shift_w-1:0]          frame_shift;
  logic signed [coef_width-1:0] coeff [tap_count];
  logic signed [sig_width-1:0] dline [chan_count][tap_count];
  logic signed [acc_width-1:0] acc [chan_count];
  logic signed [prod_w-1:0]    prod [chan_count];
  logic signed [acc_width:0]   rounded [chan_count];
  logic signed [acc_width:0]   rnd_bias;
  logic [chan_count*sig_width-1:0] result;
`ifdef FIR_SAT_EN
  localparam logic signed [acc_width:0] sat_max = (acc_width+1)'((1 << (sig_width-1)) - 1);
  localparam logic signed [acc_width:0] sat_min = (acc_width+1)'(-(1 << (sig_width-1)));
  logic signed [acc_width:0]   shifted [chan_count];
`endif

  assign cc_rising = conv_done & ~cc_prev;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cc_rising) state_d = MAC;
        MAC:     if (tap_k == last_tap) state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Round-half-up bias for the frame shift; a zero shift passes the accumulator through.
  assign rnd_bias = (frame_shift == '0) ? '0
                  : ((acc_width+1)'(1) << (frame_shift - 1'b1));

  always_comb begin
    result = '0;
    for (int c = 0; c < chan_count; c++) begin
      prod[c]    = prod_w'(dline[c][rptr]) * prod_w'(coeff[tap_k]);
      rounded[c] = {acc[c][acc_width-1], acc[c]} + rnd_bias;
`ifdef FIR_SAT_EN
      shifted[c] = rounded[c] >>> frame_shift;
      if (shifted[c] > sat_max)
        result[c*sig_width +: sig_width] = sig_width'(sat_max);
      else if (shifted[c] < sat_min)
        result[c*sig_width +: sig_width] = sig_width'(sat_min);
      else
        result[c*sig_width +: sig_width] = sig_width'(shifted[c]);
`else
      result[c*sig_width +: sig_width] = sig_width'(rounded[c] >>> frame_shift);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cc_prev     <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      tap_k       <= '0;
      frame_shift <= '0;
      shift_r     <= shift_w'(coef_width - 2);
      coef_ack    <= 1'b0;
      coef_rdata  <= '0;
      filt_out    <= '0;
      filt_done   <= 1'b0;
      overrun     <= 1'b0;
      for (int t = 0; t < tap_count; t++) coeff[t] <= '0;
      coeff[0] <= coef_width'(1 << (coef_width - 2));
      for (int c = 0; c < chan_count; c++) begin
        acc[c] <= '0;
        for (int t = 0; t < tap_count; t++) dline[c][t] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cc_prev    <= conv_done;
      coef_ack   <= 1'b0;
      filt_done  <= 1'b0;
      coef_rdata <= coeff[coef_addr];
      if (shift_we) shift_r <= shift_i;
      // Coefficients only change between frames so a running MAC never sees a torn set.
      if (coef_we && state_q == IDLE) begin
        coeff[coef_addr] <= coef_wdata;
        coef_ack         <= 1'b1;
      end
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        tap_k    <= '0;
        filt_out <= '0;
        overrun  <= 1'b0;
        for (int c = 0; c < chan_count; c++) begin
          acc[c] <= '0;
          for (int t = 0; t < tap_count; t++) dline[c][t] <= '0;
        end
      end else begin
        if (cc_rising && state_q != IDLE) overrun <= 1'b1;
        case (state_q)
          IDLE: begin
            if (cc_rising) begin
              for (int c = 0; c < chan_count; c++) begin
                dline[c][wptr] <= adc_in[c*sig_width +: sig_width];
                acc[c]         <= '0;
              end
              wptr        <= (wptr == last_tap) ? '0 : wptr + 1'b1;
              rptr        <= wptr;
              tap_k       <= '0;
              frame_shift <= shift_r;
            end
          end
          MAC: begin
            for (int c = 0; c < chan_count; c++)
              acc[c] <= acc[c] + {{(acc_width-prod_w){prod[c][prod_w-1]}}, prod[c]};
            tap_k <= tap_k + 1'b1;
            rptr  <= (rptr == '0) ? last_tap : rptr - 1'b1;
          end
          OUT: begin
            filt_out  <= result;
            filt_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
